// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-addressed cache: lane extract/extend, sub-word RMW.
// Latency accept->resp: error 1, load/word store 2, sub-word store 3 cycles.
// Backpressure: one request in flight; req_ready_o only in IDLE, response held until resp_ready_i.
module load_store_unit #(
    parameter int WORD_BITS = 32,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [1:0]           req_size_i,
    input  logic                 req_signed_i,
    input  logic [ADDR_BITS-1:0] req_addr_i,
    input  logic [WORD_BITS-1:0] req_wdata_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [WORD_BITS-1:0] resp_rdata_o,
    output logic                 resp_err_o,
    output logic [ADDR_BITS-1:0] cache_addr_o,
    input  logic [WORD_BITS-1:0] cache_rd_data_i,
    output logic [WORD_BITS-1:0] cache_wr_data_o,
    output logic                 cache_wr_en_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t               state;
    logic                 we_q;
    logic [1:0]           size_q;
    logic                 sgn_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [WORD_BITS-1:0] wdata_q;
    logic [WORD_BITS-1:0] rdata_q;
    logic                 err_q;
    logic                 vld_q;
    logic                 wr_en_q;
    logic [WORD_BITS-1:0] wr_data_q;

    logic                 bad_req;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [WORD_BITS-1:0] load_data;
    logic [WORD_BITS-1:0] merged;

    assign bad_req = (req_size_i == 2'b11)
                   | ((req_size_i == SZ_HALF) & req_addr_i[0])
                   | ((req_size_i == SZ_WORD) & (|req_addr_i[1:0]));

    always_comb begin
        byte_sel  = cache_rd_data_i[7:0];
        half_sel  = addr_q[1] ? cache_rd_data_i[31:16] : cache_rd_data_i[15:0];
        load_data = cache_rd_data_i;
        merged    = cache_rd_data_i;
        case (addr_q[1:0])
            2'd0:    byte_sel = cache_rd_data_i[7:0];
            2'd1:    byte_sel = cache_rd_data_i[15:8];
            2'd2:    byte_sel = cache_rd_data_i[23:16];
            default: byte_sel = cache_rd_data_i[31:24];
        endcase
        if (size_q == SZ_BYTE)
            load_data = {{(WORD_BITS-8){sgn_q & byte_sel[7]}}, byte_sel};
        else if (size_q == SZ_HALF)
            load_data = {{(WORD_BITS-16){sgn_q & half_sel[15]}}, half_sel};
        // Only the addressed lane of the old word is replaced; the rest is written back as read.
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            sgn_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            vld_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        size_q  <= req_size_i;
                        sgn_q   <= req_signed_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        if (bad_req) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            vld_q   <= 1'b1;
                            state   <= RESP;
                        end else begin
                            // Whole-word stores need no read, so the write is issued in ACCESS.
                            if (req_we_i && req_size_i == SZ_WORD) begin
                                wr_en_q   <= 1'b1;
                                wr_data_q <= req_wdata_i;
                            end
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= load_data;
                        vld_q   <= 1'b1;
                        state   <= RESP;
                    end else if (size_q == SZ_WORD) begin
                        wr_en_q <= 1'b0;
                        rdata_q <= '0;
                        vld_q   <= 1'b1;
                        state   <= RESP;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= merged;
                        state     <= MERGE;
                    end
                end
                MERGE: begin
                    wr_en_q <= 1'b0;
                    rdata_q <= '0;
                    vld_q   <= 1'b1;
                    state   <= RESP;
                end
                default: begin
                    if (resp_ready_i) begin
                        vld_q   <= 1'b0;
                        err_q   <= 1'b0;
                        rdata_q <= '0;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready_o     = reset_ni & (state == IDLE);
    assign resp_valid_o    = vld_q;
    assign resp_rdata_o    = rdata_q;
    assign resp_err_o      = err_q;
    assign cache_addr_o    = {addr_q[ADDR_BITS-1:2], 2'b00};
    assign cache_wr_data_o = wr_data_q;
    assign cache_wr_en_o   = wr_en_q;

endmodule
